// File: rtl/apb_pad_array.sv
// APB3 slave polling up to four NES-style serial gamepads over a shared
// latch/clock pair. Provides latest button data, sticky press edges,
// a frame counter and a new-data flag.
module apb_pad_array #(
  parameter int unsigned NUM_PADS = 2,
  parameter int unsigned NUM_BITS = 8,
  parameter int unsigned CLK_DIV  = 150
) (
  input  logic                PCLK,
  input  logic                PRESERN,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [31:0]         PADDR,
  input  logic [31:0]         PWDATA,
  output logic [31:0]         PRDATA,
  output logic                PREADY,
  output logic                PSLVERR,
  output logic                pad_latch,
  output logic                pad_clock,
  input  logic [NUM_PADS-1:0] pad_data
);

  localparam int unsigned DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned KW = $clog2(NUM_BITS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LATCH  = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_CLKHI  = 3'd3;
  localparam logic [2:0] S_CLKLO  = 3'd4;
  localparam logic [2:0] S_COMMIT = 3'd5;

  logic                en;
  logic                cont;
  logic                start_pend;
  logic [2:0]          state;
  logic [DW-1:0]       div;
  logic                tick;
  logic [KW-1:0]       k;
  logic [NUM_BITS-1:0] sh      [NUM_PADS];
  logic [NUM_BITS-1:0] data_r  [NUM_PADS];
  logic [NUM_BITS-1:0] pressed [NUM_PADS];
  logic [7:0]          frame;
  logic                new_flag;

  logic [11:0]         off;
  logic                sel_ctrl;
  logic                sel_stat;
  logic [NUM_PADS-1:0] hit_data;
  logic [NUM_PADS-1:0] hit_pr;
  logic                mapped;
  logic [31:0]         rdata;
  logic                setup_rd;
  logic                wr_acc;
  logic                busy;
  logic                commit_now;

  // Bits outside the decoded window are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{PADDR[31:12], PWDATA};

  assign PREADY     = 1'b1;
  assign PSLVERR    = PSEL & PENABLE & ~mapped;
  assign setup_rd   = PSEL & ~PENABLE & ~PWRITE;
  assign wr_acc     = PSEL & PENABLE & PWRITE & mapped;
  assign busy       = (state != S_IDLE);
  assign tick       = en && (div == DW'(CLK_DIV - 1));
  assign commit_now = en && (state == S_COMMIT);

  // Address decode of the 12-bit register window.
  always_comb begin
    off      = PADDR[11:0];
    sel_ctrl = (off == 12'h000);
    sel_stat = (off == 12'h004);
    hit_data = '0;
    hit_pr   = '0;
    for (int unsigned i = 0; i < NUM_PADS; i++) begin
      hit_data[i] = (off == 12'(32'h10 + 4 * i));
      hit_pr[i]   = (off == 12'(32'h30 + 4 * i));
    end
    mapped = sel_ctrl | sel_stat | (|hit_data) | (|hit_pr);
  end

  // Read data mux; unmapped offsets and unused bits read as zero.
  always_comb begin
    rdata = '0;
    if (sel_ctrl) begin
      rdata[1:0] = {cont, en};
    end
    if (sel_stat) begin
      rdata[0]    = busy;
      rdata[1]    = new_flag;
      rdata[15:8] = frame;
    end
    for (int unsigned i = 0; i < NUM_PADS; i++) begin
      if (hit_data[i]) rdata[NUM_BITS-1:0] = data_r[i];
      if (hit_pr[i])   rdata[NUM_BITS-1:0] = pressed[i];
    end
  end

  // PRDATA is captured in the setup phase and held through the access phase.
  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      PRDATA <= '0;
    end else if (setup_rd) begin
      PRDATA <= rdata;
    end
  end

  // Control register and pending single-shot request.
  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      en         <= 1'b0;
      cont       <= 1'b0;
      start_pend <= 1'b0;
    end else begin
      if (wr_acc && sel_ctrl) begin
        en   <= PWDATA[0];
        cont <= PWDATA[1];
      end
      if (wr_acc && sel_ctrl && PWDATA[0] && PWDATA[2] && !busy) begin
        start_pend <= 1'b1;
      end else if (!en) begin
        start_pend <= 1'b0;
      end else if (tick && !busy && (cont || start_pend)) begin
        start_pend <= 1'b0;
      end
    end
  end

  // Pad tick divider, parked at zero while disabled.
  always_ff @(posedge PCLK) begin
    if (!PRESERN || !en || tick) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  // Pad sequencer: latch pulse, then alternating clock phases with sampling.
  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      state     <= S_IDLE;
      pad_latch <= 1'b0;
      pad_clock <= 1'b0;
      k         <= '0;
      frame     <= '0;
      for (int unsigned i = 0; i < NUM_PADS; i++) begin
        sh[i]     <= '0;
        data_r[i] <= '0;
      end
    end else if (!en) begin
      state     <= S_IDLE;
      pad_latch <= 1'b0;
      pad_clock <= 1'b0;
      k         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tick && (cont || start_pend)) begin
            state     <= S_LATCH;
            pad_latch <= 1'b1;
          end
        end
        S_LATCH: begin
          if (tick) begin
            state     <= S_SAMPLE;
            pad_latch <= 1'b0;
            k         <= KW'(1);
            // Fresh frame: any bits left from an aborted frame are dropped.
            for (int unsigned i = 0; i < NUM_PADS; i++) begin
              sh[i] <= {{(NUM_BITS-1){1'b0}}, ~pad_data[i]};
            end
          end
        end
        S_SAMPLE, S_CLKLO: begin
          if (tick) begin
            state     <= S_CLKHI;
            pad_clock <= 1'b1;
          end
        end
        S_CLKHI: begin
          if (tick) begin
            pad_clock <= 1'b0;
            k         <= k + KW'(1);
            for (int unsigned i = 0; i < NUM_PADS; i++) begin
              sh[i] <= {sh[i][NUM_BITS-2:0], ~pad_data[i]};
            end
            state <= (k == KW'(NUM_BITS - 1)) ? S_COMMIT : S_CLKLO;
          end
        end
        S_COMMIT: begin
          for (int unsigned i = 0; i < NUM_PADS; i++) begin
            data_r[i] <= sh[i];
          end
          frame <= frame + 8'd1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky press edges (set beats clear) and the new-data flag.
  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      new_flag <= 1'b0;
      for (int unsigned i = 0; i < NUM_PADS; i++) begin
        pressed[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_PADS; i++) begin
        pressed[i] <= (pressed[i] & ~((wr_acc && hit_pr[i]) ? PWDATA[NUM_BITS-1:0] : '0))
                    | (commit_now ? (sh[i] & ~data_r[i]) : '0);
      end
      if (commit_now) begin
        new_flag <= 1'b1;
      end else if (setup_rd && sel_stat) begin
        new_flag <= 1'b0;
      end
    end
  end

endmodule
